button_strobe: RTL

- Input conditioning stage directly upstream of the turn-indicator walker.
- Takes two raw, asynchronous, bouncy push-button levels (left, right).
- Synchronises and debounces each button, and emits one single-cycle strobe per clean press.
- Feeds the walker's left/right strobe inputs. Also exports debounced held levels for status LEDs and for test.

---
 rtl/button_strobe.sv | 138 +++++++++++++
 1 files changed

// File: rtl/button_strobe.sv
// rtl/button_strobe.sv - two-button synchroniser, debouncer and press strobe generator
// Each button runs an independent 2-flop synchroniser feeding a 4-state debounce FSM.

module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic stb,
  output logic held
);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync_meta;
  logic             sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      state     <= RELEASED;
      cnt       <= '0;
      stb       <= 1'b0;
      held      <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync      <= sync_meta;
      stb       <= 1'b0;
      case (state)
        RELEASED: begin
          if (sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            stb   <= 1'b1;
            held  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= REL_WAIT;
            cnt   <= '0;
          end
        end
        REL_WAIT: begin
          // A bounce back to 1 returns to HELD silently; only a full stable release clears held.
          if (sync) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= RELEASED;
            held  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FORMAL
  logic past_valid = 1'b0;
  always_ff @(posedge clk) past_valid <= 1'b1;
  always_ff @(posedge clk) begin
    if (past_valid && !reset) begin
      assert (!(stb && $past(stb)));
      assert (!stb || held);
      assert (cnt < CNT_W'(DEBOUNCE_CYCLES));
      assert (state inside {RELEASED, PRESS_WAIT, HELD, REL_WAIT});
    end
  end
`endif

endmodule

module button_strobe #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_left_btn,
  input  logic i_right_btn,
  output logic o_left_stb,
  output logic o_right_stb,
  output logic o_left_held,
  output logic o_right_held
);

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_left (
    .clk  (i_clk),
    .reset(i_reset),
    .btn  (i_left_btn),
    .stb  (o_left_stb),
    .held (o_left_held)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_right (
    .clk  (i_clk),
    .reset(i_reset),
    .btn  (i_right_btn),
    .stb  (o_right_stb),
    .held (o_right_held)
  );

endmodule
